// File: rtl/voice_allocator_pkg.sv
// Shared FSM encodings and MIDI constants for the voice allocator.
package voice_allocator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] MIDI_STATUS_NOTE_ON = 4'h9;
    localparam logic [6:0] MIDI_DATA_MASK      = 7'h7F;

    // A note-on with velocity zero is treated as a note-off.
    function automatic logic is_note_on(input logic [6:0] velocity);
        return velocity != 7'd0;
    endfunction

endpackage

// File: rtl/voice_slot.sv
// Storage for one synth voice: active flag, held note and (with VOICE_STEAL_EN) a saturating age.
module voice_slot
`ifdef VOICE_STEAL_EN
#(
    parameter int AGE_W = 8
)
`endif
(
    input  logic             clk,
    input  logic             resetq,
    input  logic [6:0]       cmp_note,
    input  logic             load_en,
    input  logic             clear_en,
`ifdef VOICE_STEAL_EN
    input  logic             age_en,
    output logic [AGE_W-1:0] age,
`endif
    output logic             active,
    output logic             match
);

    logic       active_q, active_d;
    logic [6:0] note_q, note_d;

    always_comb begin
        active_d = active_q;
        note_d   = note_q;
        if (load_en) begin
            active_d = 1'b1;
            note_d   = cmp_note;
        end else if (clear_en) begin
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            active_q <= 1'b0;
            note_q   <= 7'd0;
        end else begin
            active_q <= active_d;
            note_q   <= note_d;
        end
    end

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0] age_q, age_d;

    always_comb begin
        age_d = age_q;
        if (load_en) begin
            age_d = '0;
        end else if (age_en && active_q && (age_q != '1)) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    assign age = age_q;
`endif

    assign active = active_q;
    assign match  = active_q && (note_q == cmp_note);

endmodule

// File: rtl/voice_allocator.sv
// MIDI note allocator: scans voices one per cycle, then loads, retriggers, releases or steals one voice.
// Optional feature macro: VOICE_STEAL_EN (steal the oldest voice when all are busy).
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NVOICES = 4,
    parameter int AGE_W   = 8
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [7:0]         msg_note,
    input  logic [7:0]         msg_velocity,
    output logic [NVOICES-1:0] voice_load,
    output logic [7:0]         voice_note,
    output logic [7:0]         voice_velocity,
    output logic [NVOICES-1:0] voice_active,
    output logic               drop,
    output logic               steal
);

    localparam int IDX_W = $clog2(NVOICES);

    if (NVOICES < 2 || NVOICES > 8 || AGE_W < 1) begin : g_param_check
        $error("voice_allocator: NVOICES must be 2..8 and AGE_W at least 1");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [6:0]       note_q, note_d;
    logic [6:0]       vel_q, vel_d;
    logic             match_hit_q, match_hit_d;
    logic [IDX_W-1:0] match_idx_q, match_idx_d;
    logic             free_hit_q, free_hit_d;
    logic [IDX_W-1:0] free_idx_q, free_idx_d;

    logic [NVOICES-1:0] slot_active, slot_match;
    logic [NVOICES-1:0] load_vec, clear_vec;
    logic [IDX_W-1:0]   sel_idx;
    logic               do_load;
    logic               unused_bits;

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0]   slot_age [NVOICES];
    logic [NVOICES-1:0] age_vec;
    logic [IDX_W-1:0]   old_idx_q, old_idx_d;
    logic [AGE_W-1:0]   old_age_q, old_age_d;
    logic               steal_c;
`else
    logic               drop_c;
`endif

    assign unused_bits = ^{msg_note[7], msg_velocity[7], MIDI_STATUS_NOTE_ON};

    for (genvar gi = 0; gi < NVOICES; gi++) begin : g_slot
        voice_slot
`ifdef VOICE_STEAL_EN
            #(.AGE_W(AGE_W))
`endif
            u_slot (
            .clk      (clk),
            .resetq   (resetq),
            .cmp_note (note_q),
            .load_en  (load_vec[gi]),
            .clear_en (clear_vec[gi]),
`ifdef VOICE_STEAL_EN
            .age_en   (age_vec[gi]),
            .age      (slot_age[gi]),
`endif
            .active   (slot_active[gi]),
            .match    (slot_match[gi])
        );
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        note_d      = note_q;
        vel_d       = vel_q;
        match_hit_d = match_hit_q;
        match_idx_d = match_idx_q;
        free_hit_d  = free_hit_q;
        free_idx_d  = free_idx_q;
        msg_ready   = 1'b0;
        load_vec    = '0;
        clear_vec   = '0;
        sel_idx     = '0;
        do_load     = 1'b0;
`ifdef VOICE_STEAL_EN
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        steal_c     = 1'b0;
`else
        drop_c      = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    note_d      = msg_note[6:0] & MIDI_DATA_MASK;
                    vel_d       = msg_velocity[6:0] & MIDI_DATA_MASK;
                    idx_d       = '0;
                    match_hit_d = 1'b0;
                    match_idx_d = '0;
                    free_hit_d  = 1'b0;
                    free_idx_d  = '0;
`ifdef VOICE_STEAL_EN
                    old_idx_d   = '0;
                    old_age_d   = '0;
`endif
                    state_d     = ST_SCAN;
                end
            end

            ST_SCAN: begin
                // First hit wins, so each tracker ends up holding the lowest qualifying index.
                if (slot_match[idx_q] && !match_hit_q) begin
                    match_hit_d = 1'b1;
                    match_idx_d = idx_q;
                end
                if (!slot_active[idx_q] && !free_hit_q) begin
                    free_hit_d = 1'b1;
                    free_idx_d = idx_q;
                end
`ifdef VOICE_STEAL_EN
                // Strictly greater keeps the lowest index on ties; only consulted when all are active.
                if (slot_active[idx_q] && (slot_age[idx_q] > old_age_q)) begin
                    old_age_d = slot_age[idx_q];
                    old_idx_d = idx_q;
                end
`endif
                if (idx_q == IDX_W'(NVOICES - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (is_note_on(vel_q)) begin
                    if (match_hit_q) begin
                        sel_idx = match_idx_q;
                        do_load = 1'b1;
                    end else if (free_hit_q) begin
                        sel_idx = free_idx_q;
                        do_load = 1'b1;
                    end else begin
`ifdef VOICE_STEAL_EN
                        sel_idx = old_idx_q;
                        do_load = 1'b1;
                        steal_c = 1'b1;
`else
                        drop_c  = 1'b1;
`endif
                    end
                    if (do_load) begin
                        load_vec[sel_idx] = 1'b1;
                    end
                end else if (match_hit_q) begin
                    clear_vec[match_idx_q] = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

`ifdef VOICE_STEAL_EN
    assign age_vec = do_load ? (slot_active & ~load_vec) : '0;
`endif

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            note_q      <= 7'd0;
            vel_q       <= 7'd0;
            match_hit_q <= 1'b0;
            match_idx_q <= '0;
            free_hit_q  <= 1'b0;
            free_idx_q  <= '0;
`ifdef VOICE_STEAL_EN
            old_idx_q   <= '0;
            old_age_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            match_hit_q <= match_hit_d;
            match_idx_q <= match_idx_d;
            free_hit_q  <= free_hit_d;
            free_idx_q  <= free_idx_d;
`ifdef VOICE_STEAL_EN
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
`endif
        end
    end

    assign voice_load     = load_vec | clear_vec;
    assign voice_note     = {1'b0, note_q};
    assign voice_velocity = {1'b0, vel_q};
    assign voice_active   = slot_active;
`ifdef VOICE_STEAL_EN
    assign steal = steal_c;
    assign drop  = 1'b0;
`else
    assign steal = 1'b0;
    assign drop  = drop_c;
`endif

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NVOICES, default 4, number of synth voices driven (range 2..8).
REQ-002 SHALL have parameter AGE_W, default 8, width of per-voice saturating age counter.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port resetq  input  1  asynchronous active-low reset.
REQ-005 SHALL have port msg_valid  input  1  MIDI note event present (note-on; velocity 0 = note-off).
REQ-006 SHALL have port msg_ready  output  1  allocator can accept an event this cycle.
REQ-007 SHALL have port msg_note  input  8  MIDI note number; bit 7 ignored.
REQ-008 SHALL have port msg_velocity  input  8  MIDI velocity; bit 7 ignored.
REQ-009 SHALL have port voice_load  output  NVOICES  one-hot, one-cycle strobe to the selected voice's message_received.
REQ-010 SHALL have port voice_note  output  8  note broadcast to all voices, valid with voice_load.
REQ-011 SHALL have port voice_velocity  output  8  velocity broadcast, valid with voice_load.
REQ-012 SHALL have port voice_active  output  NVOICES  per-voice sounding flag.
REQ-013 SHALL have port drop  output  1  one-cycle pulse: note-on discarded.
REQ-014 SHALL have port steal  output  1  one-cycle pulse: active voice reassigned.

Function
REQ-015 SHALL hold per voice: active bit, 7-bit note, AGE_W-bit age.
REQ-016 SHALL implement FSM IDLE -> SCAN -> COMMIT -> IDLE; msg_ready=1 only in IDLE.
REQ-017 SHALL accept an event when msg_valid & msg_ready, latching note[6:0] and velocity[6:0], entering SCAN.
REQ-018 SCAN SHALL examine one voice per cycle, index 0..NVOICES-1, for exactly NVOICES cycles, then enter COMMIT.
REQ-019 Note-on selection priority SHALL be: active voice with same note (retrigger), else lowest-index inactive voice, else active voice with greatest age (ties -> lowest index).
REQ-020 Note-off SHALL select the lowest-index active voice holding the note; if none, COMMIT emits no strobe.
REQ-021 COMMIT SHALL assert voice_load for exactly one cycle with latched note/velocity; accept-to-strobe latency = NVOICES+1 cycles.
REQ-022 On note-on commit, selected voice SHALL become active with age 0; every other active voice SHALL increment age, saturating at all-ones.
REQ-023 On note-off commit, selected voice SHALL become inactive; ages unchanged.
REQ-024 steal SHALL pulse in COMMIT when a note-on replaces a voice holding a different note.
REQ-025 msg_valid while msg_ready=0 SHALL be ignored (not queued).
REQ-026 voice_load, drop, steal SHALL be 0 outside COMMIT.

Reset
REQ-027 resetq low SHALL asynchronously force state IDLE, all active=0, ages=0, notes=0, voice_load=0, voice_note=0, voice_velocity=0, drop=0, steal=0.
REQ-028 Reset mid-SCAN/COMMIT SHALL abandon the event with no strobe; msg_ready=1 first cycle after release.

Configuration
REQ-029 Macro VOICE_STEAL_EN defined: REQ-019 third choice applies.
REQ-030 VOICE_STEAL_EN undefined: note-on with all voices active and no note match SHALL emit no strobe, pulse drop in COMMIT; steal tied 0; age logic removable.

Structure
REQ-031 Shared package SHALL hold FSM state encodings and MIDI constants (note-on status 4'h9, 7-bit data mask).
REQ-032 One sub-module voice_slot (active/note/age storage and match compare) SHALL be instantiated NVOICES times.

Verification
REQ-033 Reset, note-on 60 vel 100 -> voice_load=4'b0001 five cycles after accept, voice_active=4'b0001.
REQ-034 Note-ons 60,62,64,65 then note-off 62 (vel 0) -> voice_load=4'b0010 with velocity 0, voice_active=4'b1101.
REQ-035 Four voices full (60,62,64,65), note-on 67 with VOICE_STEAL_EN -> voice_load=4'b0001, steal=1; without macro -> no strobe, drop=1.
REQ-036 Note-on 60 twice -> second strobe to voice 0, active count 1, steal=0.
REQ-037 msg_valid held during SCAN -> ignored; resetq pulsed mid-SCAN -> no voice_load, voice_active=0.
